// File: rtl/page_pkg.sv
// page_pkg: shared definitions for the page stream bridge.
//   kstate_t  - kernel start/run control FSM states
//   STAT_BITS - width of each per-channel transfer counter
//   clog2()   - elaboration-time ceiling log2 helper for pointer sizing
package page_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } kstate_t;

  localparam int STAT_BITS = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/page_chan_fifo.sv
// page_chan_fifo: one decoupling FIFO channel with valid/ack on both sides.
//   clk, reset        - clock, synchronous active-high reset (pointers only)
//   wr_data/wr_vld    - write side data and valid
//   wr_ack            - write side accept, derived from registered state only
//   rd_data/rd_vld    - read side data (zero when empty) and valid
//   rd_ack            - read side accept
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module page_chan_fifo
  import page_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_vld,
  output logic             wr_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_vld,
  input  logic             rd_ack
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // A pop on a full FIFO does not free the slot for the same cycle's push:
  // ack is a pure function of the registered pointers.
  assign wr_ack = !full;
  assign push   = wr_vld && !full;
  assign pop    = rd_ack && !empty;

  assign rd_vld  = !empty;
  // Gating with empty keeps the output at zero out of reset without
  // having to reset the storage array.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/page_stream_bridge.sv
// page_stream_bridge: buffering and start control between a page's
// leaf_interface and its HLS kernel.
//   clk, reset                    - clock, synchronous active-high reset
//   din_if/vld_if/ack_if          - interface -> bridge, per input channel
//   dout_krn/vld_krn/ack_krn      - bridge -> kernel Input_k
//   din_krn/vld_krn_out/ack_krn_out - kernel Output_k -> bridge
//   dout_if/vld_if_out/ack_if_out - bridge -> interface, per output channel
//   kernel_go                     - one-shot start request (AUTO_RESTART=0)
//   ap_start/ap_ready/ap_done     - kernel block-level control
//   busy                          - high while in START or RUN
//   stat_words                    - per-channel read-side transfer counters,
//                                   only when PAGE_BRIDGE_STATS_EN is defined
// Counter order in stat_words: input channels first, then output channels.
module page_stream_bridge
  import page_pkg::*;
#(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 1,
  parameter int NUM_OUT_PORTS = 1,
  parameter int FIFO_DEPTH    = 4,
  parameter int AUTO_RESTART  = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  din_if,
  input  logic [NUM_IN_PORTS-1:0]               vld_if,
  output logic [NUM_IN_PORTS-1:0]               ack_if,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_krn,
  output logic [NUM_IN_PORTS-1:0]               vld_krn,
  input  logic [NUM_IN_PORTS-1:0]               ack_krn,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_krn,
  input  logic [NUM_OUT_PORTS-1:0]              vld_krn_out,
  output logic [NUM_OUT_PORTS-1:0]              ack_krn_out,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] dout_if,
  output logic [NUM_OUT_PORTS-1:0]              vld_if_out,
  input  logic [NUM_OUT_PORTS-1:0]              ack_if_out,
  input  logic                                  kernel_go,
  output logic                                  ap_start,
  input  logic                                  ap_ready,
  input  logic                                  ap_done,
  output logic                                  busy
`ifdef PAGE_BRIDGE_STATS_EN
  ,
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*STAT_BITS-1:0] stat_words
`endif
);

  localparam logic AUTO = (AUTO_RESTART != 0);

  // ---- channel FIFOs: interface -> kernel ----
  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    page_chan_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_data (din_if[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_vld  (vld_if[i]),
      .wr_ack  (ack_if[i]),
      .rd_data (dout_krn[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld  (vld_krn[i]),
      .rd_ack  (ack_krn[i])
    );
  end

  // ---- channel FIFOs: kernel -> interface ----
  for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_out
    page_chan_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_data (din_krn[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_vld  (vld_krn_out[i]),
      .wr_ack  (ack_krn_out[i]),
      .rd_data (dout_if[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld  (vld_if_out[i]),
      .rd_ack  (ack_if_out[i])
    );
  end

  // ---- kernel control FSM ----
  kstate_t state;
  kstate_t next_state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ap_start   = 1'b0;
    case (state)
      IDLE: begin
        // kernel_go is only looked at here, so requests while busy are dropped.
        if (AUTO || kernel_go) next_state = START;
      end
      START: begin
        ap_start = 1'b1;
        if (ap_ready) next_state = (!AUTO && ap_done) ? IDLE : RUN;
      end
      RUN: begin
        // Free-running mode keeps ap_start high so the kernel re-launches.
        ap_start = AUTO;
        if (!AUTO && ap_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == START) || (state == RUN);

`ifdef PAGE_BRIDGE_STATS_EN
  // ---- read-side transfer counters ----
  logic [NUM_IN_PORTS+NUM_OUT_PORTS-1:0] rd_xfer;
  assign rd_xfer = {vld_if_out & ack_if_out, vld_krn & ack_krn};

  for (genvar c = 0; c < NUM_IN_PORTS + NUM_OUT_PORTS; c++) begin : g_stat
    logic [STAT_BITS-1:0] cnt;
    always_ff @(posedge clk) begin
      if (reset)           cnt <= '0;
      else if (rd_xfer[c]) cnt <= cnt + 1'b1;
    end
    assign stat_words[c*STAT_BITS +: STAT_BITS] = cnt;
  end
`endif

endmodule

// File: tb/tb_page_stream_bridge.sv
// tb_page_stream_bridge: directed self-checking bench for page_stream_bridge.
// u_dut : one-shot control, 1 input channel, 2 output channels, depth 4.
// u_free: free-running control with default parameters.
// Stat counter checks are compiled in when PAGE_BRIDGE_STATS_EN is defined.
module tb_page_stream_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [31:0] din_if = '0;
  logic        vld_if = 1'b0;
  logic        ack_if;
  logic [31:0] dout_krn;
  logic        vld_krn;
  logic        ack_krn = 1'b0;
  logic [63:0] din_krn = '0;
  logic [1:0]  vld_krn_out = '0;
  logic [1:0]  ack_krn_out;
  logic [63:0] dout_if;
  logic [1:0]  vld_if_out;
  logic [1:0]  ack_if_out = '0;
  logic        kernel_go = 1'b0;
  logic        ap_start;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        busy;

  logic        f_ack_if;
  logic [31:0] f_dout_krn;
  logic        f_vld_krn;
  logic        f_ack_krn_out;
  logic [31:0] f_dout_if;
  logic        f_vld_if_out;
  logic        f_ap_start;
  logic        f_ap_ready = 1'b0;
  logic        f_ap_done = 1'b0;
  logic        f_busy;

`ifdef PAGE_BRIDGE_STATS_EN
  logic [95:0] stat_words;
  logic [63:0] f_stat_words;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  page_stream_bridge #(
    .PAYLOAD_BITS(32), .NUM_IN_PORTS(1), .NUM_OUT_PORTS(2),
    .FIFO_DEPTH(4), .AUTO_RESTART(0)
  ) u_dut (
    .clk(clk), .reset(reset),
    .din_if(din_if), .vld_if(vld_if), .ack_if(ack_if),
    .dout_krn(dout_krn), .vld_krn(vld_krn), .ack_krn(ack_krn),
    .din_krn(din_krn), .vld_krn_out(vld_krn_out), .ack_krn_out(ack_krn_out),
    .dout_if(dout_if), .vld_if_out(vld_if_out), .ack_if_out(ack_if_out),
    .kernel_go(kernel_go), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .busy(busy)
`ifdef PAGE_BRIDGE_STATS_EN
    , .stat_words(stat_words)
`endif
  );

  page_stream_bridge u_free (
    .clk(clk), .reset(reset),
    .din_if(32'h0), .vld_if(1'b0), .ack_if(f_ack_if),
    .dout_krn(f_dout_krn), .vld_krn(f_vld_krn), .ack_krn(1'b0),
    .din_krn(32'h0), .vld_krn_out(1'b0), .ack_krn_out(f_ack_krn_out),
    .dout_if(f_dout_if), .vld_if_out(f_vld_if_out), .ack_if_out(1'b0),
    .kernel_go(1'b0), .ap_start(f_ap_start), .ap_ready(f_ap_ready),
    .ap_done(f_ap_done), .busy(f_busy)
`ifdef PAGE_BRIDGE_STATS_EN
    , .stat_words(f_stat_words)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic [31:0] w [6];

  initial begin
    for (int i = 0; i < 6; i++) w[i] = 32'h100 + 32'(i);

    // Reset state
    tick(); tick();
    chk("rst_ack_if", 64'(ack_if), 64'(1));
    chk("rst_ack_krn_out", 64'(ack_krn_out), 64'(2'b11));
    chk("rst_vld_krn", 64'(vld_krn), 64'(0));
    chk("rst_vld_if_out", 64'(vld_if_out), 64'(0));
    chk("rst_dout_krn", 64'(dout_krn), 64'(0));
    chk("rst_dout_if", 64'(dout_if), 64'(0));
    chk("rst_ap_start", 64'(ap_start), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_free_ap_start", 64'(f_ap_start), 64'(0));
`ifdef PAGE_BRIDGE_STATS_EN
    chk("rst_stat", 64'(stat_words[31:0]), 64'(0));
`endif

    // Free-running start timing and one-shot idling
    reset = 1'b0;
    chk("free_pre_start", 64'(f_ap_start), 64'(0));
    tick();
    chk("free_ap_start", 64'(f_ap_start), 64'(1));
    chk("free_busy", 64'(f_busy), 64'(1));
    chk("oneshot_idle", 64'(ap_start), 64'(0));
    f_ap_ready = 1'b1; tick(); f_ap_ready = 1'b0;
    chk("free_run_start", 64'(f_ap_start), 64'(1));
    f_ap_done = 1'b1; tick(); f_ap_done = 1'b0;
    chk("free_done_stay", 64'(f_busy), 64'(1));
    chk("free_done_start", 64'(f_ap_start), 64'(1));

    // Single word
    din_if = 32'hDEADBEEF; vld_if = 1'b1;
    tick();
    vld_if = 1'b0;
    chk("single_vld", 64'(vld_krn), 64'(1));
    chk("single_data", 64'(dout_krn), 64'(32'hDEADBEEF));
    ack_krn = 1'b1; tick(); ack_krn = 1'b0;
    chk("single_popped", 64'(vld_krn), 64'(0));
    chk("single_dout0", 64'(dout_krn), 64'(0));

    // Fill with kernel stalled
    for (int i = 0; i < 4; i++) begin
      din_if = w[i]; vld_if = 1'b1;
      chk("fill_ack_hi", 64'(ack_if), 64'(1));
      tick();
    end
    chk("fill_full_ack", 64'(ack_if), 64'(0));
    chk("fill_vld", 64'(vld_krn), 64'(1));
    chk("fill_head", 64'(dout_krn), 64'(w[0]));
    din_if = w[4];
    tick();
    chk("fill_still_full", 64'(ack_if), 64'(0));
    chk("fill_hold", 64'(dout_krn), 64'(w[0]));
    ack_krn = 1'b1; tick(); ack_krn = 1'b0;
    chk("fill_ack_back", 64'(ack_if), 64'(1));
    chk("fill_head2", 64'(dout_krn), 64'(w[1]));
    tick();
    chk("fill_refull", 64'(ack_if), 64'(0));
    vld_if = 1'b0;
    ack_krn = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk("fill_order_vld", 64'(vld_krn), 64'(1));
      chk("fill_order", 64'(dout_krn), 64'(w[i]));
      tick();
    end
    ack_krn = 1'b0;
    chk("fill_drained", 64'(vld_krn), 64'(0));

    // Independence of output channels
    vld_krn_out = 2'b11; ack_if_out = 2'b10;
    for (int j = 0; j < 8; j++) begin
      din_krn = {32'hB00 + 32'(j), 32'hA00 + 32'(j)};
      tick();
      chk("ind_ch1_vld", 64'(vld_if_out[1]), 64'(1));
      chk("ind_ch1_data", 64'(dout_if[63:32]), 64'(32'hB00 + 32'(j)));
      chk("ind_ch1_ack", 64'(ack_krn_out[1]), 64'(1));
      chk("ind_ch0_ack", 64'(ack_krn_out[0]), 64'(j < 3));
      chk("ind_ch0_hold", 64'(dout_if[31:0]), 64'(32'hA00));
    end
    vld_krn_out = 2'b00;
    tick();
    chk("ind_ch1_empty", 64'(vld_if_out[1]), 64'(0));
    ack_if_out = 2'b01;
    for (int j = 0; j < 4; j++) begin
      chk("ind_ch0_data", 64'(dout_if[31:0]), 64'(32'hA00 + 32'(j)));
      tick();
    end
    chk("ind_ch0_empty", 64'(vld_if_out[0]), 64'(0));
    ack_if_out = 2'b00;

    // One-shot control
    kernel_go = 1'b1; tick(); kernel_go = 1'b0;
    chk("os_start", 64'(ap_start), 64'(1));
    chk("os_busy", 64'(busy), 64'(1));
    tick();
    chk("os_start_hold", 64'(ap_start), 64'(1));
    ap_ready = 1'b1; tick(); ap_ready = 1'b0;
    chk("os_run_start", 64'(ap_start), 64'(0));
    chk("os_run_busy", 64'(busy), 64'(1));
    kernel_go = 1'b1; tick(); kernel_go = 1'b0;
    chk("os_go_ignored", 64'(ap_start), 64'(0));
    ap_done = 1'b1; tick(); ap_done = 1'b0;
    chk("os_done_idle", 64'(busy), 64'(0));
    chk("os_done_start", 64'(ap_start), 64'(0));
    kernel_go = 1'b1; tick(); kernel_go = 1'b0;
    chk("os_restart", 64'(ap_start), 64'(1));
    ap_ready = 1'b1; ap_done = 1'b1; tick(); ap_ready = 1'b0; ap_done = 1'b0;
    chk("os_ready_done", 64'(busy), 64'(0));

    // Reset mid-stream with buffered words and a running kernel
    kernel_go = 1'b1; tick(); kernel_go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_if = 32'hC00 + 32'(i); vld_if = 1'b1;
      tick();
    end
    vld_if = 1'b0;
    vld_krn_out = 2'b01; din_krn = 64'h0000_0000_0000_0E00;
    tick();
    vld_krn_out = 2'b00;
    chk("mid_buffered", 64'(vld_krn), 64'(1));
    chk("mid_busy", 64'(busy), 64'(1));
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mrst_vld_krn", 64'(vld_krn), 64'(0));
    chk("mrst_vld_if_out", 64'(vld_if_out), 64'(0));
    chk("mrst_ack_if", 64'(ack_if), 64'(1));
    chk("mrst_ack_krn_out", 64'(ack_krn_out), 64'(2'b11));
    chk("mrst_ap_start", 64'(ap_start), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_dout", 64'(dout_krn), 64'(0));
    chk("mrst_free_start", 64'(f_ap_start), 64'(0));
    ack_krn = 1'b1; ack_if_out = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_no_stale", 64'(vld_krn), 64'(0));
      chk("mrst_no_stale_out", 64'(vld_if_out), 64'(0));
    end
    ack_if_out = 2'b00;

`ifdef PAGE_BRIDGE_STATS_EN
    chk("stat_cleared", 64'(stat_words[31:0]), 64'(0));
    for (int i = 0; i < 10; i++) begin
      din_if = 32'hD00 + 32'(i); vld_if = 1'b1;
      tick();
    end
    vld_if = 1'b0;
    tick(); tick();
    chk("stat_ten", 64'(stat_words[31:0]), 64'(10));
    chk("stat_out0", 64'(stat_words[63:32]), 64'(0));
`endif
    ack_krn = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
